axil_bus_monitor: RTL and testbench

AXI4-Lite slave that passively snoops one AXI4-Lite bus and exposes transaction statistics, plus a parametrised bank of scratch registers, through its own AXI4-Lite register interface. It generalises the fixed 4-register bus monitor slave with these additions:
- configurable scratch count and counter width;
- saturating write/read/error counters;
- last-write-address capture;
- maximum write-latency tracking.

It sits beside an AXI4-Lite interconnect port, with monitor inputs tapped from that port and the slave interface on the control interconnect.

---
 rtl/axil_bus_monitor_if.sv | 54 +++++
 rtl/axil_bus_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_axil_bus_monitor.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_bus_monitor_if.sv
// AXI4-Lite register slave port plus the passive tap of the monitored bus.
// The monitor signals are inputs only; the block never drives the snooped port.
interface axil_bus_monitor_if #(
    parameter int S_ADDR_WIDTH   = 6,
    parameter int MON_ADDR_WIDTH = 32
);
    logic [S_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;
    logic [31:0]               s_axi_wdata;
    logic [3:0]                s_axi_wstrb;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;
    logic [1:0]                s_axi_bresp;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;
    logic [S_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;
    logic [31:0]               s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;

    logic [MON_ADDR_WIDTH-1:0] mon_awaddr;
    logic                      mon_awvalid;
    logic                      mon_awready;
    logic                      mon_bvalid;
    logic                      mon_bready;
    logic [1:0]                mon_bresp;
    logic                      mon_arvalid;
    logic                      mon_arready;
    logic                      mon_rvalid;
    logic                      mon_rready;
    logic [1:0]                mon_rresp;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  mon_awaddr, mon_awvalid, mon_awready, mon_bvalid, mon_bready, mon_bresp,
        input  mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rresp
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output mon_awaddr, mon_awvalid, mon_awready, mon_bvalid, mon_bready, mon_bresp,
        output mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rresp
    );
endinterface

// File: rtl/axil_bus_monitor.sv
// Passive AXI4-Lite bus monitor: saturating transaction counters, last write address,
// max write latency and a scratch bank, all exposed through an AXI4-Lite register slave.
module axil_bus_monitor #(
    parameter int          NUM_SCRATCH    = 4,
    parameter int          CNT_WIDTH      = 32,
    parameter int          MON_ADDR_WIDTH = 32,
    parameter int          S_ADDR_WIDTH   = 6,
    parameter logic [31:0] ID_VALUE       = 32'h424D_0002
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    axil_bus_monitor_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int                   SCR_END = 8 + NUM_SCRATCH;

    typedef enum logic {ST_IDLE, ST_TIMING} lat_state_t;

    lat_state_t           r_state, w_state_nxt;
    logic                 r_en, r_sat;
    logic                 r_bvalid, r_rvalid;
    logic [1:0]           r_bresp, r_rresp;
    logic [31:0]          r_rdata;
    logic [CNT_WIDTH-1:0] r_wr_cnt, r_rd_cnt, r_err_cnt, r_lat, r_max_wlat;
    logic [31:0]          r_last_waddr;
    logic [31:0]          r_scratch [NUM_SCRATCH];

    logic                 w_wr_hs, w_rd_hs, w_wr_bad, w_ctrl_wr, w_clr;
    logic [31:0]          w_wr_idx, w_rd_idx, w_rd_data;
    logic                 w_rd_err;
    logic                 w_aw_hs, w_b_hs, w_r_hs;
    logic [1:0]           w_wr_inc, w_rd_inc, w_err_inc;
    logic [CNT_WIDTH:0]   w_wr_sum, w_rd_sum, w_err_sum;
    logic [CNT_WIDTH-1:0] w_lat_inc;
    logic                 w_unused;

    // Ready is combinational so the register update lands on the same edge as the handshake.
    assign w_wr_hs = ARESETN && bus.s_axi_awvalid && bus.s_axi_wvalid && !r_bvalid;
    assign w_rd_hs = ARESETN && bus.s_axi_arvalid && !r_rvalid;

    assign bus.s_axi_awready = w_wr_hs;
    assign bus.s_axi_wready  = w_wr_hs;
    assign bus.s_axi_arready = w_rd_hs;
    assign bus.s_axi_bvalid  = r_bvalid;
    assign bus.s_axi_bresp   = r_bresp;
    assign bus.s_axi_rvalid  = r_rvalid;
    assign bus.s_axi_rresp   = r_rresp;
    assign bus.s_axi_rdata   = r_rdata;

    assign w_wr_idx  = 32'(bus.s_axi_awaddr[S_ADDR_WIDTH-1:2]);
    assign w_rd_idx  = 32'(bus.s_axi_araddr[S_ADDR_WIDTH-1:2]);
    assign w_wr_bad  = w_wr_idx >= 32'(SCR_END);
    assign w_ctrl_wr = w_wr_hs && (w_wr_idx == 32'd0) && bus.s_axi_wstrb[0];
    assign w_clr     = w_ctrl_wr && bus.s_axi_wdata[1];

    assign w_aw_hs = bus.mon_awvalid && bus.mon_awready;
    assign w_b_hs  = bus.mon_bvalid && bus.mon_bready;
    assign w_r_hs  = bus.mon_rvalid && bus.mon_rready;

    assign w_wr_inc  = {1'b0, r_en && w_b_hs};
    assign w_rd_inc  = {1'b0, r_en && w_r_hs};
    assign w_err_inc = {1'b0, r_en && w_b_hs && bus.mon_bresp[1]}
                     + {1'b0, r_en && w_r_hs && bus.mon_rresp[1]};

    // Returns {saturation_hit, clamped_value}.
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        if (s >= {1'b0, CNT_MAX})
            return {inc != 2'd0, CNT_MAX};
        return {1'b0, s[CNT_WIDTH-1:0]};
    endfunction

    assign w_wr_sum  = sat_add(r_wr_cnt, w_wr_inc);
    assign w_rd_sum  = sat_add(r_rd_cnt, w_rd_inc);
    assign w_err_sum = sat_add(r_err_cnt, w_err_inc);
    assign w_lat_inc = (r_lat == CNT_MAX) ? CNT_MAX : r_lat + 1'b1;

    assign w_unused = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0], bus.mon_bresp[0],
                        bus.mon_rresp[0], bus.mon_arvalid, bus.mon_arready};

    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_en <= 1'b1;
        else if (w_ctrl_wr)
            r_en <= bus.s_axi_wdata[0];
    end

    // CLR takes priority over any monitor event on the same edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || w_clr) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_wr_cnt  <= w_wr_sum[CNT_WIDTH-1:0];
            r_rd_cnt  <= w_rd_sum[CNT_WIDTH-1:0];
            r_err_cnt <= w_err_sum[CNT_WIDTH-1:0];
            if (w_wr_sum[CNT_WIDTH] || w_rd_sum[CNT_WIDTH] || w_err_sum[CNT_WIDTH])
                r_sat <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_last_waddr <= '0;
        else if (w_aw_hs)
            r_last_waddr <= 32'(bus.mon_awaddr);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (r_en && w_aw_hs && !w_b_hs) w_state_nxt = ST_TIMING;
            ST_TIMING: if (w_b_hs) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_clr)
            w_state_nxt = ST_IDLE;
    end

    // lat holds cycles elapsed since the AW edge; the B edge itself counts as one more.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || w_clr) begin
            r_lat      <= '0;
            r_max_wlat <= '0;
        end else if (r_state == ST_TIMING) begin
            if (w_b_hs) begin
                if (w_lat_inc > r_max_wlat)
                    r_max_wlat <= w_lat_inc;
            end else begin
                r_lat <= w_lat_inc;
            end
        end else begin
            r_lat <= '0;
        end
    end

    for (genvar k = 0; k < NUM_SCRATCH; k++) begin : g_scratch
        always_ff @(posedge ACLK) begin
            if (!ARESETN)
                r_scratch[k] <= '0;
            else if (w_wr_hs && (w_wr_idx == 32'(8 + k)))
                for (int b = 0; b < 4; b++)
                    if (bus.s_axi_wstrb[b])
                        r_scratch[k][8*b +: 8] <= bus.s_axi_wdata[8*b +: 8];
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_rd_idx)
            32'd0:   w_rd_data = {31'b0, r_en};
            32'd1:   w_rd_data = {30'b0, r_state == ST_TIMING, r_sat};
            32'd2:   w_rd_data = 32'(r_wr_cnt);
            32'd3:   w_rd_data = 32'(r_rd_cnt);
            32'd4:   w_rd_data = 32'(r_err_cnt);
            32'd5:   w_rd_data = r_last_waddr;
            32'd6:   w_rd_data = 32'(r_max_wlat);
            32'd7:   w_rd_data = ID_VALUE;
            default: w_rd_err  = 1'b1;
        endcase
        for (int k = 0; k < NUM_SCRATCH; k++) begin
            if (w_rd_idx == 32'(8 + k)) begin
                w_rd_data = r_scratch[k];
                w_rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_bad ? 2'b10 : 2'b00;
        end else if (r_bvalid && bus.s_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && bus.s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_bus_monitor.sv
// Directed bench for axil_bus_monitor: expected responses are queued by the stimulus
// and popped by an independent monitor whenever a B or R handshake is about to happen.
module tb_axil_bus_monitor;
    localparam int SAW = 6;
    localparam int MAW = 32;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;

    axil_bus_monitor_if #(.S_ADDR_WIDTH(SAW), .MON_ADDR_WIDTH(MAW)) bus();

    axil_bus_monitor #(
        .NUM_SCRATCH(4), .CNT_WIDTH(8), .MON_ADDR_WIDTH(MAW),
        .S_ADDR_WIDTH(SAW), .ID_VALUE(32'h424D_0002)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // bready/rready only change just after a rising edge, so sampling here is race-free.
    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        forever begin
            @(negedge ACLK);
            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (bq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL bresp_unexpected: got resp 0x%0h with nothing queued", bus.s_axi_bresp);
                end else begin
                    eb = bq.pop_front();
                    chk("bresp", 32'(bus.s_axi_bresp), 32'(eb));
                end
            end
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (rq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rdata_unexpected: got 0x%08h with nothing queued", bus.s_axi_rdata);
                end else begin
                    er = rq.pop_front();
                    chk("rdata", bus.s_axi_rdata, er[31:0]);
                    chk("rresp", 32'(bus.s_axi_rresp), 32'(er[33:32]));
                end
            end
        end
    end

    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp);
        int n;
        bq.push_back(exp);
        @(negedge ACLK);
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        #1;
        n = 0;
        while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        if (n >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL wr_timeout: no awready for addr 0x%0h", a);
            void'(bq.pop_back());
        end
        @(negedge ACLK);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_rd(input logic [5:0] a, input logic [31:0] d, input logic [1:0] exp);
        int n;
        rq.push_back({exp, d});
        @(negedge ACLK);
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_axi_arready && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        if (n >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL rd_timeout: no arready for addr 0x%0h", a);
            void'(rq.pop_back());
        end
        @(negedge ACLK);
        bus.s_axi_arvalid = 1'b0;
    endtask

    // One monitored handshake on the edge following the next falling edge.
    task automatic mon_hs(input logic b, input logic [1:0] br, input logic r, input logic [1:0] rr);
        @(negedge ACLK);
        bus.mon_bvalid = b; bus.mon_bready = b; bus.mon_bresp = br;
        bus.mon_rvalid = r; bus.mon_rready = r; bus.mon_rresp = rr;
        @(negedge ACLK);
        bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0; bus.mon_bresp = 2'b00;
        bus.mon_rvalid = 1'b0; bus.mon_rready = 1'b0; bus.mon_rresp = 2'b00;
    endtask

    task automatic mon_aw(input logic [31:0] a);
        @(negedge ACLK);
        bus.mon_awaddr = a; bus.mon_awvalid = 1'b1; bus.mon_awready = 1'b1;
        @(negedge ACLK);
        bus.mon_awvalid = 1'b0; bus.mon_awready = 1'b0;
    endtask

    initial begin
        int n;
        bus.s_axi_awaddr = '0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr = '0; bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        bus.mon_awaddr = '0; bus.mon_awvalid = 1'b0; bus.mon_awready = 1'b0;
        bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0; bus.mon_bresp = 2'b00;
        bus.mon_arvalid = 1'b0; bus.mon_arready = 1'b0;
        bus.mon_rvalid = 1'b0; bus.mon_rready = 1'b0; bus.mon_rresp = 2'b00;

        // Reset with valids asserted: all slave outputs must still read 0
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        chk("rst_wready",  32'(bus.s_axi_wready),  32'd0);
        chk("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        chk("rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        chk("rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
        chk("rst_bresp",   32'(bus.s_axi_bresp),   32'd0);
        chk("rst_rresp",   32'(bus.s_axi_rresp),   32'd0);
        chk("rst_rdata",   bus.s_axi_rdata,        32'd0);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        ARESETN = 1'b1;

        axi_rd(6'h00, 32'h1, 2'b00);
        axi_rd(6'h08, 32'h0, 2'b00);
        axi_rd(6'h1C, 32'h424D0002, 2'b00);
        axi_rd(6'h04, 32'h0, 2'b00);

        // Scratch bank and byte strobes
        for (int k = 0; k < 4; k++) axi_wr(6'(6'h20 + 4*k), 32'(k + 1), 4'hF, 2'b00);
        for (int k = 0; k < 4; k++) axi_rd(6'(6'h20 + 4*k), 32'(k + 1), 2'b00);
        axi_wr(6'h20, 32'hAABBCCDD, 4'b0010, 2'b00);
        axi_rd(6'h20, 32'h0000CC01, 2'b00);

        axi_wr(6'h08, 32'h55, 4'hF, 2'b00);
        axi_rd(6'h08, 32'h0, 2'b00);

        // Counting: B error and R error land on the same edge
        repeat (4) mon_hs(1'b1, 2'b00, 1'b0, 2'b00);
        mon_hs(1'b1, 2'b10, 1'b1, 2'b11);
        repeat (2) mon_hs(1'b0, 2'b00, 1'b1, 2'b00);
        axi_rd(6'h08, 32'd5, 2'b00);
        axi_rd(6'h0C, 32'd3, 2'b00);
        axi_rd(6'h10, 32'd2, 2'b00);

        // Latency: B three edges after AW
        mon_aw(32'h1000);
        repeat (1) @(negedge ACLK);
        mon_hs(1'b1, 2'b00, 1'b0, 2'b00);
        axi_rd(6'h18, 32'd3, 2'b00);
        // B seven edges after AW, with a second AW ignored while timing
        mon_aw(32'h2000);
        repeat (1) @(negedge ACLK);
        mon_aw(32'h3000);
        repeat (2) @(negedge ACLK);
        mon_hs(1'b1, 2'b00, 1'b0, 2'b00);
        axi_rd(6'h18, 32'd7, 2'b00);
        axi_rd(6'h14, 32'h3000, 2'b00);
        // LAT_BUSY visible while a write is outstanding
        mon_aw(32'h4000);
        axi_rd(6'h04, 32'h2, 2'b00);
        mon_hs(1'b1, 2'b00, 1'b0, 2'b00);
        axi_rd(6'h18, 32'd7, 2'b00);
        axi_rd(6'h14, 32'h4000, 2'b00);

        // EN=0 freezes counters and tracker but still captures AW address
        axi_wr(6'h00, 32'h0, 4'hF, 2'b00);
        axi_rd(6'h00, 32'h0, 2'b00);
        mon_aw(32'h5000);
        mon_hs(1'b1, 2'b10, 1'b0, 2'b00);
        axi_rd(6'h08, 32'd8, 2'b00);
        axi_rd(6'h10, 32'd2, 2'b00);
        axi_rd(6'h14, 32'h5000, 2'b00);
        axi_rd(6'h04, 32'h0, 2'b00);
        axi_wr(6'h00, 32'h1, 4'hF, 2'b00);

        // Saturation: 260 more B handshakes on an 8-bit counter
        @(negedge ACLK);
        bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1;
        repeat (260) @(negedge ACLK);
        bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
        axi_rd(6'h08, 32'hFF, 2'b00);
        axi_rd(6'h04, 32'h1, 2'b00);
        axi_rd(6'h10, 32'd2, 2'b00);

        // CLR on the same edge as a monitored B handshake
        @(negedge ACLK);
        bus.mon_bvalid = 1'b1; bus.mon_bready = 1'b1;
        axi_wr(6'h00, 32'h3, 4'hF, 2'b00);
        bus.mon_bvalid = 1'b0; bus.mon_bready = 1'b0;
        axi_rd(6'h08, 32'h0, 2'b00);
        axi_rd(6'h04, 32'h0, 2'b00);
        axi_rd(6'h00, 32'h1, 2'b00);
        axi_rd(6'h0C, 32'h0, 2'b00);
        axi_rd(6'h10, 32'h0, 2'b00);
        axi_rd(6'h18, 32'h0, 2'b00);
        axi_rd(6'h14, 32'h5000, 2'b00);
        axi_rd(6'h24, 32'h2, 2'b00);

        // Out-of-range accesses
        axi_rd(6'h3C, 32'h0, 2'b10);
        axi_rd(6'h30, 32'h0, 2'b10);
        axi_wr(6'h30, 32'hDEAD, 4'hF, 2'b10);
        axi_rd(6'h2C, 32'h4, 2'b00);

        // Read backpressure: data holds and a queued AR is not accepted
        rq.push_back({2'b00, 32'h2});
        rq.push_back({2'b00, 32'h3});
        @(posedge ACLK); #1 bus.s_axi_rready = 1'b0;
        @(negedge ACLK);
        bus.s_axi_araddr = 6'h24; bus.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_axi_arready && n < 50) begin @(negedge ACLK); #1; n++; end
        @(negedge ACLK);
        bus.s_axi_araddr = 6'h28;
        repeat (10) begin
            #1;
            chk("bp_rvalid",  32'(bus.s_axi_rvalid),  32'd1);
            chk("bp_rdata",   bus.s_axi_rdata,        32'h2);
            chk("bp_arready", 32'(bus.s_axi_arready), 32'd0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1 bus.s_axi_rready = 1'b1;
        n = 0;
        do begin @(negedge ACLK); #1; n++; end while (!bus.s_axi_arready && n < 50);
        if (n >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL bp_timeout: second AR never accepted");
        end
        @(negedge ACLK);
        bus.s_axi_arvalid = 1'b0;

        // Reset with a write response pending
        @(posedge ACLK); #1 bus.s_axi_bready = 1'b0;
        @(negedge ACLK);
        bus.s_axi_awaddr = 6'h20; bus.s_axi_wdata = 32'h77; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        @(negedge ACLK);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        #1;
        chk("pre_rst_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        bus.s_axi_bready = 1'b1;
        ARESETN = 1'b1;
        axi_rd(6'h20, 32'h0, 2'b00);
        axi_rd(6'h00, 32'h1, 2'b00);
        axi_rd(6'h14, 32'h0, 2'b00);

        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin @(negedge ACLK); n++; end
        if (bq.size() != 0 || rq.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain: %0d B and %0d R responses never arrived", bq.size(), rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
